// File: rtl/prbs_link_pkg.sv
// Shared types and constants for the PRBS7 lane bring-up sequencer.
package prbs_link_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RST      = 3'd1,
      ST_WAIT_PLL = 3'd2,
      ST_WAIT_SD  = 3'd3,
      ST_WAIT_CDR = 3'd4,
      ST_ALIGN    = 3'd5,
      ST_UP       = 3'd6,
      ST_BACKOFF  = 3'd7
   } state_e;

   localparam int unsigned DEF_RST_CYCLES    = 64;
   localparam int unsigned DEF_LOCK_TIMEOUT  = 65535;
   localparam int unsigned DEF_ALIGN_TIMEOUT = 4095;
   localparam int unsigned DEF_SD_STABLE     = 16;
   localparam int unsigned DEF_MAX_RETRY     = 7;
   localparam int unsigned DEF_ERR_CNT_W     = 32;

   // Shared timer must hold the largest terminal count of any timed state.
   function automatic int unsigned timer_w(input int unsigned lock_to,
                                           input int unsigned align_to,
                                           input int unsigned rst_cycles);
      int unsigned m;
      m = lock_to;
      if (align_to > m) m = align_to;
      if (rst_cycles > m) m = rst_cycles;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous PHY status inputs.
module sync_2ff (
   input  logic clk_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_p0;
   logic sync_p1;

   always_ff @(posedge clk_i) begin
      meta_p0 <= d_i;
      sync_p1 <= meta_p0;
   end

   assign q_o = sync_p1;

endmodule

// File: rtl/prbs_link_seq.sv
// Per-lane SerDes bring-up sequencer: RX reset, lock stepping, PRBS7 alignment,
// error counting while up, and bounded automatic retries.
module prbs_link_seq
   import prbs_link_pkg::*;
#(
   parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
   parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int unsigned ALIGN_TIMEOUT = DEF_ALIGN_TIMEOUT,
   parameter int unsigned SD_STABLE     = DEF_SD_STABLE,
   parameter int unsigned MAX_RETRY     = DEF_MAX_RETRY,
   parameter int unsigned ERR_CNT_W     = DEF_ERR_CNT_W
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 stop_i,
   input  logic                 clear_cnt_i,
   input  logic                 pll_lock_i,
   input  logic                 signal_detect_i,
   input  logic                 cdr_lock_i,
   input  logic                 prbs_lock_i,
   input  logic                 prbs_err_i,
   output logic                 phy_rx_rst_o,
   output logic                 prbs_chk_en_o,
   output logic                 link_up_o,
   output logic                 fail_o,
   output logic [ERR_CNT_W-1:0] err_cnt_o,
   output logic [2:0]           retry_cnt_o,
   output logic [2:0]           state_o
);

   localparam int unsigned TMR_W = timer_w(LOCK_TIMEOUT, ALIGN_TIMEOUT, RST_CYCLES);
   localparam int unsigned SD_W  = $clog2(SD_STABLE + 1);

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   state_e                 state, state_nxt;
   logic [TMR_W-1:0]       timer;
   logic [SD_W-1:0]        sd_cnt;
   logic [2:0]             retry_cnt;
   logic                   fail;
   logic [ERR_CNT_W-1:0]   err_cnt;
   logic                   pll_s, sd_s, cdr_s;
   logic                   state_chg;

   sync_2ff u_sync_pll (.clk_i(clk_i), .d_i(pll_lock_i),      .q_o(pll_s));
   sync_2ff u_sync_sd  (.clk_i(clk_i), .d_i(signal_detect_i), .q_o(sd_s));
   sync_2ff u_sync_cdr (.clk_i(clk_i), .d_i(cdr_lock_i),      .q_o(cdr_s));

   // stop_i overrides every transition; in IDLE it also blocks a start.
   always_comb begin
      state_nxt = state;
      if (stop_i) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:     if (start_i) state_nxt = ST_RST;
            ST_RST:      if (timer == TMR_W'(RST_CYCLES - 1)) state_nxt = ST_WAIT_PLL;
            ST_WAIT_PLL: begin
               if (pll_s)                               state_nxt = ST_WAIT_SD;
               else if (timer == TMR_W'(LOCK_TIMEOUT))  state_nxt = ST_BACKOFF;
            end
            ST_WAIT_SD: begin
               if (sd_s && sd_cnt == SD_W'(SD_STABLE - 1)) state_nxt = ST_WAIT_CDR;
               else if (timer == TMR_W'(LOCK_TIMEOUT))     state_nxt = ST_BACKOFF;
            end
            ST_WAIT_CDR: begin
               if (cdr_s)                               state_nxt = ST_ALIGN;
               else if (timer == TMR_W'(LOCK_TIMEOUT))  state_nxt = ST_BACKOFF;
            end
            ST_ALIGN: begin
               if (!pll_s || !cdr_s)                    state_nxt = ST_BACKOFF;
               else if (prbs_lock_i)                    state_nxt = ST_UP;
               else if (timer == TMR_W'(ALIGN_TIMEOUT)) state_nxt = ST_BACKOFF;
            end
            ST_UP:       if (!pll_s || !sd_s || !cdr_s || !prbs_lock_i) state_nxt = ST_BACKOFF;
            ST_BACKOFF:  state_nxt = (retry_cnt == 3'(MAX_RETRY)) ? ST_IDLE : ST_RST;
            default:     state_nxt = ST_IDLE;
         endcase
      end
   end

   assign state_chg = (state_nxt != state);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= ST_IDLE;
         timer     <= '0;
         sd_cnt    <= '0;
         retry_cnt <= '0;
         fail      <= 1'b0;
         err_cnt   <= '0;
      end else begin
         state  <= state_nxt;
         timer  <= state_chg ? '0 : timer + 1'b1;
         // Stability run restarts on any low sample but leaves the timer alone.
         sd_cnt <= (state == ST_WAIT_SD && sd_s && !state_chg) ? sd_cnt + 1'b1 : '0;

         if (state == ST_IDLE && state_nxt == ST_RST)
            retry_cnt <= '0;
         else if (state == ST_BACKOFF && state_nxt == ST_RST)
            retry_cnt <= retry_cnt + 3'd1;
         else if (state != ST_UP && state_nxt == ST_UP)
            retry_cnt <= '0;

         if (state == ST_IDLE && state_nxt == ST_RST)
            fail <= 1'b0;
         else if (state == ST_BACKOFF && state_nxt == ST_IDLE && !stop_i)
            fail <= 1'b1;

         if (clear_cnt_i)
            err_cnt <= '0;
         else if (state == ST_UP && prbs_err_i)
            err_cnt <= sat_inc(err_cnt);
      end
   end

   assign phy_rx_rst_o  = (state == ST_IDLE) || (state == ST_RST) || (state == ST_BACKOFF);
   assign prbs_chk_en_o = (state == ST_ALIGN) || (state == ST_UP);
   assign link_up_o     = (state == ST_UP);
   assign fail_o        = fail;
   assign err_cnt_o     = err_cnt;
   assign retry_cnt_o   = retry_cnt;
   assign state_o       = state;

endmodule

// File: tb/tb_prbs_link_seq.sv
// Directed bench for prbs_link_seq: bring-up, error counting, lock loss,
// signal-detect glitch, stop, mid-run reset, and retry exhaustion.
module tb_prbs_link_seq;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // Instance A: default timing, narrow error counter.
   logic       start = 0, stop = 0, clear_cnt = 0;
   logic       pll = 0, sd = 0, cdr = 0, plock = 0, perr = 0;
   logic       phy_rst, chk_en, link_up, fail;
   logic [3:0] err_cnt;
   logic [2:0] retry, state;

   // Instance B: short lock timeout, two retries.
   logic       start_b = 0, stop_b = 0, zero_b = 0;
   logic       phy_rst_b, chk_en_b, link_b, fail_b;
   logic [31:0] err_b;
   logic [2:0] retry_b, state_b;

   int total = 0;
   int bad   = 0;

   prbs_link_seq #(.ERR_CNT_W(4)) u_dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .clear_cnt_i(clear_cnt),
      .pll_lock_i(pll), .signal_detect_i(sd), .cdr_lock_i(cdr),
      .prbs_lock_i(plock), .prbs_err_i(perr),
      .phy_rx_rst_o(phy_rst), .prbs_chk_en_o(chk_en), .link_up_o(link_up), .fail_o(fail),
      .err_cnt_o(err_cnt), .retry_cnt_o(retry), .state_o(state)
   );

   prbs_link_seq #(.LOCK_TIMEOUT(100), .MAX_RETRY(2)) u_dut_b (
      .clk_i(clk), .rst_i(rst), .start_i(start_b), .stop_i(stop_b), .clear_cnt_i(zero_b),
      .pll_lock_i(zero_b), .signal_detect_i(zero_b), .cdr_lock_i(zero_b),
      .prbs_lock_i(zero_b), .prbs_err_i(zero_b),
      .phy_rx_rst_o(phy_rst_b), .prbs_chk_en_o(chk_en_b), .link_up_o(link_b), .fail_o(fail_b),
      .err_cnt_o(err_b), .retry_cnt_o(retry_b), .state_o(state_b)
   );

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(3);
      rst = 1'b0;
      total++; if (state !== 3'd0)  begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
      total++; if (phy_rst !== 1'b1) begin bad++; $display("FAIL reset_phy_rst: got %0b want 1", phy_rst); end
      total++; if (chk_en !== 1'b0)  begin bad++; $display("FAIL reset_chk_en: got %0b want 0", chk_en); end
      total++; if (link_up !== 1'b0) begin bad++; $display("FAIL reset_link: got %0b want 0", link_up); end
      total++; if (fail !== 1'b0)    begin bad++; $display("FAIL reset_fail: got %0b want 0", fail); end
      total++; if (err_cnt !== 4'd0) begin bad++; $display("FAIL reset_err: got %0d want 0", err_cnt); end
      total++; if (retry !== 3'd0)   begin bad++; $display("FAIL reset_retry: got %0d want 0", retry); end
   endtask

   task automatic test_bringup();
      int n;
      step(5);
      start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (state === 3'd1 && n < 200) begin
         if (phy_rst === 1'b1) n++;
         step();
      end
      total++; if (n != 64) begin bad++; $display("FAIL rst_cycles: got %0d want 64", n); end
      total++; if (state !== 3'd2) begin bad++; $display("FAIL enter_wait_pll: got %0d want 2", state); end
      pll = 1'b1;
      n = 0;
      while (state === 3'd2 && n < 20) begin step(); n++; end
      total++; if (n != 3 || state !== 3'd3) begin bad++; $display("FAIL pll_step: got %0d cyc st %0d want 3 cyc st 3", n, state); end
      sd = 1'b1;
      n = 0;
      while (state === 3'd3 && n < 40) begin step(); n++; end
      total++; if (n != 18 || state !== 3'd4) begin bad++; $display("FAIL sd_step: got %0d cyc st %0d want 18 cyc st 4", n, state); end
      cdr = 1'b1;
      n = 0;
      while (state === 3'd4 && n < 20) begin step(); n++; end
      total++; if (n != 3 || state !== 3'd5) begin bad++; $display("FAIL cdr_step: got %0d cyc st %0d want 3 cyc st 5", n, state); end
      total++; if (chk_en !== 1'b1 || phy_rst !== 1'b0) begin bad++; $display("FAIL align_outs: got en %0b rst %0b want 1 0", chk_en, phy_rst); end
      plock = 1'b1;
      step();
      total++; if (state !== 3'd6) begin bad++; $display("FAIL enter_up: got %0d want 6", state); end
      total++; if (link_up !== 1'b1 || chk_en !== 1'b1) begin bad++; $display("FAIL up_outs: got link %0b en %0b want 1 1", link_up, chk_en); end
      total++; if (retry !== 3'd0) begin bad++; $display("FAIL up_retry: got %0d want 0", retry); end
   endtask

   task automatic test_err_sat();
      perr = 1'b1;
      step(5);
      total++; if (err_cnt !== 4'd5) begin bad++; $display("FAIL err_count5: got %0d want 5", err_cnt); end
      step(15);
      total++; if (err_cnt !== 4'd15) begin bad++; $display("FAIL err_saturate: got %0d want 15", err_cnt); end
      clear_cnt = 1'b1;
      step();
      clear_cnt = 1'b0;
      total++; if (err_cnt !== 4'd0) begin bad++; $display("FAIL err_clear_prio: got %0d want 0", err_cnt); end
      step(3);
      perr = 1'b0;
      total++; if (err_cnt !== 4'd3) begin bad++; $display("FAIL err_recount: got %0d want 3", err_cnt); end
   endtask

   task automatic test_lock_loss();
      plock = 1'b0;
      step();
      total++; if (state !== 3'd7) begin bad++; $display("FAIL loss_backoff: got %0d want 7", state); end
      total++; if (link_up !== 1'b0 || phy_rst !== 1'b1) begin bad++; $display("FAIL loss_outs: got link %0b rst %0b want 0 1", link_up, phy_rst); end
      step();
      total++; if (state !== 3'd1 || retry !== 3'd1) begin bad++; $display("FAIL loss_retry: got st %0d retry %0d want 1 1", state, retry); end
      total++; if (err_cnt !== 4'd3) begin bad++; $display("FAIL loss_err_kept: got %0d want 3", err_cnt); end
   endtask

   task automatic test_sd_glitch();
      int n;
      sd = 1'b0;
      cdr = 1'b0;
      n = 0;
      while (state !== 3'd3 && n < 200) begin step(); n++; end
      total++; if (state !== 3'd3) begin bad++; $display("FAIL glitch_reach_sd: got %0d want 3", state); end
      sd = 1'b1;
      step(10);
      sd = 1'b0;
      step();
      sd = 1'b1;
      total++; if (state !== 3'd3) begin bad++; $display("FAIL glitch_hold: got %0d want 3", state); end
      n = 0;
      while (state === 3'd3 && n < 60) begin step(); n++; end
      total++; if (n != 18 || state !== 3'd4) begin bad++; $display("FAIL glitch_run: got %0d cyc st %0d want 18 cyc st 4", n, state); end
   endtask

   task automatic test_stop();
      stop = 1'b1;
      step();
      stop = 1'b0;
      total++; if (state !== 3'd0 || chk_en !== 1'b0) begin bad++; $display("FAIL stop_idle: got st %0d en %0b want 0 0", state, chk_en); end
      total++; if (phy_rst !== 1'b1) begin bad++; $display("FAIL stop_phy_rst: got %0b want 1", phy_rst); end
   endtask

   task automatic test_reset_mid_align();
      int n;
      start = 1'b1;
      step();
      start = 1'b0;
      total++; if (state !== 3'd1 || retry !== 3'd0) begin bad++; $display("FAIL restart: got st %0d retry %0d want 1 0", state, retry); end
      cdr = 1'b1;
      n = 0;
      while (state !== 3'd5 && n < 200) begin step(); n++; end
      total++; if (state !== 3'd5 || chk_en !== 1'b1) begin bad++; $display("FAIL reach_align: got st %0d en %0b want 5 1", state, chk_en); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++; if (state !== 3'd0 || phy_rst !== 1'b1 || chk_en !== 1'b0 || link_up !== 1'b0)
         begin bad++; $display("FAIL midrst_ctrl: got st %0d rst %0b en %0b link %0b want 0 1 0 0", state, phy_rst, chk_en, link_up); end
      total++; if (fail !== 1'b0 || err_cnt !== 4'd0 || retry !== 3'd0)
         begin bad++; $display("FAIL midrst_cnt: got fail %0b err %0d retry %0d want 0 0 0", fail, err_cnt, retry); end
   endtask

   task automatic test_timeout();
      int visits, nent, pll_cyc, n;
      int seq [4];
      logic [2:0] prev;
      visits = 0; nent = 0; pll_cyc = 0; n = 0;
      seq = '{default: -1};
      start_b = 1'b1;
      step();
      start_b = 1'b0;
      prev = state_b;
      while (fail_b !== 1'b1 && n < 2000) begin
         step();
         n++;
         if (state_b === 3'd7) visits++;
         if (state_b === 3'd2 && visits == 0) pll_cyc++;
         if (state_b === 3'd1 && prev !== 3'd1 && nent < 4) begin seq[nent] = int'(retry_b); nent++; end
         prev = state_b;
      end
      total++; if (fail_b !== 1'b1) begin bad++; $display("FAIL to_fail_set: got %0b want 1", fail_b); end
      total++; if (visits != 3) begin bad++; $display("FAIL to_backoffs: got %0d want 3", visits); end
      total++; if (pll_cyc != 101) begin bad++; $display("FAIL to_pll_cycles: got %0d want 101", pll_cyc); end
      total++; if (nent != 2 || seq[0] != 1 || seq[1] != 2)
         begin bad++; $display("FAIL to_retry_seq: got n %0d %0d,%0d want 2 1,2", nent, seq[0], seq[1]); end
      total++; if (state_b !== 3'd0 || retry_b !== 3'd2) begin bad++; $display("FAIL to_final: got st %0d retry %0d want 0 2", state_b, retry_b); end
      total++; if (phy_rst_b !== 1'b1 || chk_en_b !== 1'b0 || link_b !== 1'b0 || err_b !== 32'd0)
         begin bad++; $display("FAIL to_outs: got rst %0b en %0b link %0b err %0d want 1 0 0 0", phy_rst_b, chk_en_b, link_b, err_b); end
      start_b = 1'b1;
      step();
      start_b = 1'b0;
      total++; if (fail_b !== 1'b0 || retry_b !== 3'd0 || state_b !== 3'd1)
         begin bad++; $display("FAIL to_restart: got fail %0b retry %0d st %0d want 0 0 1", fail_b, retry_b, state_b); end
      stop_b = 1'b1;
      step();
      stop_b = 1'b0;
      total++; if (state_b !== 3'd0) begin bad++; $display("FAIL to_stop: got %0d want 0", state_b); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      step();
      test_reset();
      test_bringup();
      test_err_sat();
      test_lock_loss();
      test_sd_glitch();
      test_stop();
      test_reset_mid_align();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
